// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern shifter.
// Holds the step-mode encoding and the bounce direction values.
package led_pkg;

    typedef enum logic [1:0] {
        FILL_L = 2'd0,
        FILL_R = 2'd1,
        ROTATE = 2'd2,
        BOUNCE = 2'd3
    } step_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_step_timer.sv
// Programmable auto-step timer: raises tick once every period_i+1 cycles while enabled.
// The counter sits at zero whenever it is cleared or disabled.
module led_step_timer #(
    parameter int PERIOD_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                auto_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] count_r;
    logic                tick_s;

    // Tick decode; a count already past a lowered period wraps naturally.
    always_comb begin
        tick_s = 1'b0;
        if (auto_en_i && (count_r == period_i)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Period counter with clear, hold-while-disabled and restart on tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {PERIOD_W{1'b0}};
        end else if (clear_i || !auto_en_i || tick_s) begin
            count_r <= {PERIOD_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern register with fill-left, fill-right, rotate and bounce step modes,
// stepped by an external strobe or the internal step timer.
module led_pattern_shifter
    import led_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PERIOD_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                step_i,
    input  step_mode_e          mode_i,
    input  logic                load_i,
    input  logic [WIDTH-1:0]    switches_i,
    input  logic                off_i,
    input  logic                auto_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic [WIDTH-1:0]    leds_o,
    output logic                full_o,
    output logic                dir_o
);

    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] leds_r;
    logic             dir_r;
    logic [WIDTH-1:0] leds_next_s;
    logic             dir_next_s;
    logic             tick_s;
    logic             step_s;
    logic             clear_s;

    assign clear_s = off_i | load_i;

    led_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_s),
        .auto_en_i (auto_en_i),
        .period_i  (period_i),
        .tick_o    (tick_s)
    );

    // A manual strobe coinciding with a tick still yields a single step.
    assign step_s = step_i | tick_s;

    // Next pattern and direction: off beats load beats step.
    always_comb begin
        leds_next_s = leds_r;
        dir_next_s  = dir_r;
        if (off_i) begin
            leds_next_s = {WIDTH{1'b0}};
            dir_next_s  = DIR_UP;
        end else if (load_i) begin
            leds_next_s = switches_i;
            dir_next_s  = dir_r;
        end else if (step_s) begin
            case (mode_i)
                FILL_L: leds_next_s = {leds_r[WIDTH-2:0], 1'b1};
                FILL_R: leds_next_s = {1'b1, leds_r[WIDTH-1:1]};
                ROTATE: leds_next_s = {leds_r[WIDTH-2:0], leds_r[WIDTH-1]};
                BOUNCE: begin
                    if (leds_r == {WIDTH{1'b0}}) begin
                        leds_next_s = LED_ONE;
                        dir_next_s  = DIR_UP;
                    end else if (dir_r == DIR_UP) begin
                        if (leds_r[WIDTH-1]) begin
                            leds_next_s = leds_r >> 1;
                            dir_next_s  = DIR_DOWN;
                        end else begin
                            leds_next_s = leds_r << 1;
                        end
                    end else begin
                        if (leds_r[0]) begin
                            leds_next_s = leds_r << 1;
                            dir_next_s  = DIR_UP;
                        end else begin
                            leds_next_s = leds_r >> 1;
                        end
                    end
                end
                default: leds_next_s = leds_r;
            endcase
        end else begin
            leds_next_s = leds_r;
            dir_next_s  = dir_r;
        end
    end

    // Pattern and direction state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            leds_r <= {WIDTH{1'b0}};
            dir_r  <= DIR_UP;
        end else begin
            leds_r <= leds_next_s;
            dir_r  <= dir_next_s;
        end
    end

    assign leds_o = leds_r;
    assign dir_o  = dir_r;
    assign full_o = &leds_r;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed bench for led_pattern_shifter: vector table plus timer and reset sequences.
module tb_led_pattern_shifter;
    import led_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             step;
    step_mode_e       mode;
    logic             load;
    logic [15:0]      sw;
    logic             off;
    logic             auto_en;
    logic [7:0]       period;
    logic [15:0]      leds;
    logic             full;
    logic             dir;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic       off;
        logic       load;
        logic [15:0] sw;
        logic       step;
        step_mode_e mode;
        logic [15:0] exp_leds;
        logic       exp_full;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[$];

    led_pattern_shifter #(.WIDTH(16), .PERIOD_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .step_i     (step),
        .mode_i     (mode),
        .load_i     (load),
        .switches_i (sw),
        .off_i      (off),
        .auto_en_i  (auto_en),
        .period_i   (period),
        .leds_o     (leds),
        .full_o     (full),
        .dir_o      (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] e_leds,
                         input logic e_full, input logic e_dir);
        tests_run++;
        if (leds !== e_leds || full !== e_full || dir !== e_dir) begin
            tests_failed++;
            $display("FAIL %s: leds=%h full=%b dir=%b, expected leds=%h full=%b dir=%b",
                     name, leds, full, dir, e_leds, e_full, e_dir);
        end
    endtask

    function automatic vec_t mk(input string n, input logic o, input logic l,
                                input logic [15:0] s, input logic st, input step_mode_e m,
                                input logic [15:0] el, input logic ef, input logic ed);
        vec_t v;
        v.name = n; v.off = o; v.load = l; v.sw = s; v.step = st; v.mode = m;
        v.exp_leds = el; v.exp_full = ef; v.exp_dir = ed;
        return v;
    endfunction

    // One clock with the given inputs, then idle inputs and sample after the edge.
    task automatic cycle(input logic o, input logic l, input logic [15:0] s,
                         input logic st, input step_mode_e m);
        off = o; load = l; sw = s; step = st; mode = m;
        @(posedge clk);
        #1;
        off = 1'b0; load = 1'b0; step = 1'b0;
    endtask

    initial begin
        logic [15:0] fill;
        rst_n = 1'b0; step = 1'b0; mode = FILL_L; load = 1'b0; sw = 16'h0000;
        off = 1'b0; auto_en = 1'b0; period = 8'd0;

        // FILL_L from zero: 17 steps, saturating at all-ones
        fill = 16'h0000;
        for (int i = 0; i < 17; i++) begin
            fill = {fill[14:0], 1'b1};
            vecs.push_back(mk($sformatf("fill_l_%0d", i + 1), 1'b0, 1'b0, 16'h0000, 1'b1,
                              FILL_L, fill, (i >= 15), 1'b0));
        end
        vecs.push_back(mk("load_drops_step", 1'b0, 1'b1, 16'h8001, 1'b1, ROTATE, 16'h8001, 1'b0, 1'b0));
        vecs.push_back(mk("rotate_wrap",     1'b0, 1'b0, 16'h0000, 1'b1, ROTATE, 16'h0003, 1'b0, 1'b0));
        vecs.push_back(mk("load_4000",       1'b0, 1'b1, 16'h4000, 1'b0, BOUNCE, 16'h4000, 1'b0, 1'b0));
        vecs.push_back(mk("bounce_up",       1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h8000, 1'b0, 1'b0));
        vecs.push_back(mk("bounce_turn_msb", 1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h4000, 1'b0, 1'b1));
        vecs.push_back(mk("bounce_down",     1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h2000, 1'b0, 1'b1));
        vecs.push_back(mk("load_keeps_dir",  1'b0, 1'b1, 16'h0001, 1'b0, BOUNCE, 16'h0001, 1'b0, 1'b1));
        vecs.push_back(mk("bounce_turn_lsb", 1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h0002, 1'b0, 1'b0));
        vecs.push_back(mk("load_8000",       1'b0, 1'b1, 16'h8000, 1'b0, BOUNCE, 16'h8000, 1'b0, 1'b0));
        vecs.push_back(mk("bounce_dir1",     1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h4000, 1'b0, 1'b1));
        vecs.push_back(mk("off_beats_all",   1'b1, 1'b1, 16'hFFFF, 1'b1, BOUNCE, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("rotate_zero",     1'b0, 1'b0, 16'h0000, 1'b1, ROTATE, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("bounce_from_0",   1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk("fill_r_step",     1'b0, 1'b0, 16'h0000, 1'b1, FILL_R, 16'h8000, 1'b0, 1'b0));
        vecs.push_back(mk("no_step_hold",    1'b0, 1'b0, 16'h0000, 1'b0, FILL_L, 16'h8000, 1'b0, 1'b0));
        vecs.push_back(mk("load_both_ends",  1'b0, 1'b1, 16'h8001, 1'b0, BOUNCE, 16'h8001, 1'b0, 1'b0));
        vecs.push_back(mk("bounce_both_up",  1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE, 16'h4000, 1'b0, 1'b1));

        #12;
        check("reset", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].off, vecs[i].load, vecs[i].sw, vecs[i].step, vecs[i].mode);
            check(vecs[i].name, vecs[i].exp_leds, vecs[i].exp_full, vecs[i].exp_dir);
        end

        // Auto-step, period 3: a step every 4 cycles; manual strobe on a tick cycle counts once
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, FILL_R);
        auto_en = 1'b1; period = 8'd3; mode = FILL_R;
        for (int c = 1; c <= 12; c++) begin
            logic [15:0] e;
            step = (c == 8);
            @(posedge clk);
            #1;
            step = 1'b0;
            e = (c < 4) ? 16'h0000 : (c < 8) ? 16'h8000 : (c < 12) ? 16'hC000 : 16'hE000;
            check($sformatf("auto_c%0d", c), e, 1'b0, 1'b0);
        end

        // off with load and step: clears everything, timer restarts from zero
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, FILL_R);
        check("auto_off", 16'h0000, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("after_off_c%0d", c), (c < 4) ? 16'h0000 : 16'h8000, 1'b0, 1'b0);
        end
        auto_en = 1'b0;

        // Asynchronous reset mid-bounce, away from any clock edge
        cycle(1'b0, 1'b1, 16'h4000, 1'b0, BOUNCE);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE);
        check("pre_reset", 16'h4000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE);
        check("resume", 16'h0001, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1, BOUNCE);
        check("resume2", 16'h0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
